// File: rtl/msrv32_data_mem_responder.sv
// msrv32_data_mem_responder
// Slave for the msrv32 core's AHB-Lite style data port. Accepts address
// phases, inserts a fixed number of wait states, then completes the
// transfer against a local word-organised RAM. Writes are byte-masked and
// reads return whole words. Misaligned or out-of-region accesses get a
// two-cycle ERROR response and never touch the RAM.
module msrv32_data_mem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] dmaddr_in,
    input  logic        dmwr_req_in,
    input  logic [3:0]  dmwr_mask_in,
    input  logic [1:0]  htrans_in,
    input  logic [31:0] dmdata_in,
    output logic        data_hready_out,
    output logic        hresp_out,
    output logic [31:0] dmdata_out
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [2:0]              cnt_r;
    logic [2:0]              cnt_next_s;
    logic [ADDR_WIDTH-1:0]   idx_r;
    logic [ADDR_WIDTH-1:0]   idx_next_s;
    logic                    wr_r;
    logic                    wr_next_s;
    logic [3:0]              mask_r;
    logic [3:0]              mask_next_s;

    logic [31:0]             mem [DEPTH];

    logic                    hready_s;
    logic                    request_s;
    logic [31:0]             offset_s;
    logic                    valid_s;
    logic                    accept_s;
    logic                    commit_s;
    state_t                  acc_state_s;
    logic [2:0]              acc_cnt_s;

    // Decode the incoming address phase: ready, request, range/alignment check.
    always_comb begin
        hready_s  = (state_r == ST_IDLE) || (state_r == ST_ERR2) ||
                    ((state_r == ST_DATA) && (cnt_r == 3'd0));
        request_s = (htrans_in == 2'b10) || (htrans_in == 2'b11);
        // BASE_ADDR is region-aligned, so an offset with no bits above the
        // word-index field lies inside the region; unsigned wrap covers
        // addresses below the base.
        offset_s  = dmaddr_in - BASE_ADDR;
        valid_s   = (offset_s[1:0] == 2'b00) &&
                    (offset_s[31:ADDR_WIDTH+2] == '0);
        accept_s  = hready_s && request_s;
        commit_s  = (state_r == ST_DATA) && (cnt_r == 3'd0) && wr_r;
    end

    // Where a state that can take a new address goes next.
    always_comb begin
        acc_state_s = ST_IDLE;
        acc_cnt_s   = 3'd0;
        if (accept_s) begin
            if (valid_s) begin
                acc_state_s = ST_DATA;
                acc_cnt_s   = WAIT_CNT;
            end else begin
                acc_state_s = ST_ERR1;
                acc_cnt_s   = 3'd0;
            end
        end else begin
            acc_state_s = ST_IDLE;
            acc_cnt_s   = 3'd0;
        end
    end

    // Next-state, wait counter and address-phase latch logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        wr_next_s    = wr_r;
        mask_next_s  = mask_r;

        if (accept_s) begin
            idx_next_s  = offset_s[ADDR_WIDTH+1:2];
            wr_next_s   = dmwr_req_in;
            mask_next_s = dmwr_mask_in;
        end else begin
            idx_next_s  = idx_r;
            wr_next_s   = wr_r;
            mask_next_s = mask_r;
        end

        case (state_r)
            ST_IDLE: begin
                state_next_s = acc_state_s;
                cnt_next_s   = acc_cnt_s;
            end
            ST_DATA: begin
                if (cnt_r != 3'd0) begin
                    state_next_s = ST_DATA;
                    cnt_next_s   = cnt_r - 3'd1;
                end else begin
                    state_next_s = acc_state_s;
                    cnt_next_s   = acc_cnt_s;
                end
            end
            ST_ERR1: begin
                // htrans is ignored here because ready is low.
                state_next_s = ST_ERR2;
                cnt_next_s   = 3'd0;
            end
            ST_ERR2: begin
                state_next_s = acc_state_s;
                cnt_next_s   = acc_cnt_s;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 3'd0;
            end
        endcase
    end

    // Control state register; reset drops any in-flight transfer.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            idx_r   <= '0;
            wr_r    <= 1'b0;
            mask_r  <= 4'h0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
            wr_r    <= wr_next_s;
            mask_r  <= mask_next_s;
        end
    end

    // Byte-masked RAM write on the completing data-phase edge; contents survive reset.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (commit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_r[i]) begin
                    mem[idx_r][8*i +: 8] <= dmdata_in[8*i +: 8];
                end
            end
        end
    end

    // Outputs depend only on registered state and RAM contents.
    always_comb begin
        data_hready_out = hready_s;
        hresp_out       = (state_r == ST_ERR1) || (state_r == ST_ERR2);
        if ((state_r == ST_DATA) && !wr_r) begin
            dmdata_out = mem[idx_r];
        end else begin
            dmdata_out = 32'h0000_0000;
        end
    end

endmodule

// File: doc/msrv32_data_mem_responder.md
# msrv32_data_mem_responder

Data-memory responder for the msrv32 core's AHB-Lite style data port, acting as the slave that answers the core's data-side requests. It accepts address phases on `htrans`, inserts a fixed number of wait states, and then completes the transfer. Writes are byte-masked into a local word-organised RAM, and reads return whole words; sign or zero extension stays in the core's load unit. Out-of-range or misaligned accesses receive a two-cycle ERROR response. The block sits outside the core top, on the `dmaddr`/`dmdata`/`dmwr_*`/`htrans` outputs and `dmdata`/`data_hready`/`hresp` inputs.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-address bits; RAM depth is 2^ADDR_WIDTH words (4 KiB by default).
- `BASE_ADDR`, default 32'h0000_2000: byte base of the region; must be aligned to 4·2^ADDR_WIDTH.
- `WAIT_STATES`, default 1: data-phase wait cycles, legal range 0..7.

Ports:
- `ms_riscv32_mp_clk_in`  in  1  clock; all state updates on the rising edge.
- `ms_riscv32_mp_rst_in`  in  1  reset; **asynchronous, active-low**.
- `dmaddr_in`  in  32  byte address, sampled in the address phase.
- `dmwr_req_in`  in  1  1 = write, 0 = read; sampled in the address phase.
- `dmwr_mask_in`  in  4  byte enables, bit i covers bits [8i+7:8i]; sampled in the address phase.
- `htrans_in`  in  2  transfer type; bit 1 set (NONSEQ/SEQ) is a transfer request, IDLE/BUSY are no request.
- `dmdata_in`  in  32  write data, sampled on the completing data-phase cycle.
- `data_hready_out`  out  1  transfer-done / ready-for-address.
- `hresp_out`  out  1  1 = ERROR response.
- `dmdata_out`  out  32  read data.

## Operation
States:
- IDLE: `data_hready_out`=1, `hresp_out`=0.
- DATA: `data_hready_out`=(cnt==0), `hresp_out`=0.
- ERR1: `data_hready_out`=0, `hresp_out`=1.
- ERR2: `data_hready_out`=1, `hresp_out`=1.

Address acceptance:
- An address is accepted on an edge where `data_hready_out`=1 and `htrans_in[1]`=1.
- On acceptance, latch the address, `dmwr_req_in` and `dmwr_mask_in`.
- An access is invalid if `dmaddr_in[1:0]`≠0 or the address lies outside [BASE_ADDR, BASE_ADDR+4·2^ADDR_WIDTH).
- Invalid access → ERR1. Valid access → DATA with cnt=WAIT_STATES.
- If `data_hready_out`=1 and there is no request → IDLE.

State transitions:
- In DATA, cnt decrements each cycle while nonzero.
- ERR1 → ERR2 unconditionally.
- ERR2 and the completing DATA cycle both use the acceptance rule above, so back-to-back pipelined transfers are supported.
- `htrans_in` is ignored whenever `data_hready_out`=0, including in ERR1.

Data path:
- Word index = (latched addr − BASE_ADDR)[ADDR_WIDTH+1:2].
- Write: on the completing DATA edge, each byte whose mask bit is 1 takes the corresponding byte of `dmdata_in`; unmasked bytes are unchanged. A mask of 4'b0000 completes normally with no change.
- Read: `dmdata_out` = RAM[word index] during every DATA cycle of a read; it is valid on the cycle `data_hready_out`=1.
- `dmdata_out` = 32'h0 at all other times, including during writes and errors.
- Errored accesses never modify the RAM.

Reset:
- Asserting reset, at any time including mid-transfer, forces IDLE and cnt=0.
- During and after reset: `data_hready_out`=1, `hresp_out`=0, `dmdata_out`=0.
- An in-flight write is dropped.
- RAM contents are not reset.

## Timing
- Address accepted at edge E0; the data phase spans WAIT_STATES+1 cycles after E0, and the last of them has `data_hready_out`=1.
- Throughput is one transfer per WAIT_STATES+1 cycles. With WAIT_STATES=0, one transfer per cycle with `data_hready_out` held at 1.
- Write commit happens at the completing edge. A read whose address phase coincides with that completing write cycle sees the new data in its own data phase.
- An error always costs exactly 2 data-phase cycles, independent of WAIT_STATES.
- Outputs are pure functions of registered state and the RAM; there is no combinational path from inputs to `data_hready_out` or `hresp_out`.

## Test plan
- **Reset:** hold `ms_riscv32_mp_rst_in`=0 → `data_hready_out`=1, `hresp_out`=0, `dmdata_out`=0. Also assert reset during the wait cycle of a write to 0x2000; after release, a read of 0x2000 returns the old value.
- **Full-word write/read, WAIT_STATES=1:** write 0xDEADBEEF with mask 4'hF to 0x2004, then read 0x2004 → one `data_hready_out`=0 cycle, then `dmdata_out`=0xDEADBEEF with `data_hready_out`=1.
- **Byte mask:** preload 0x2008=0x11223344, write 0xAABBCCDD with mask 4'b0101 → a read returns 0x11BB33DD.
- **Error cases:** access 0x2002 (misaligned) and 0x3000 (out of range with defaults) → `hresp_out`=1 for two cycles, `data_hready_out` 0 then 1, RAM unchanged.
- **Pipelined, WAIT_STATES=0:** back-to-back NONSEQ write 0x200C=0x5 then read 0x200C → `data_hready_out` held at 1 and the read returns 0x5 in the cycle after the write completes.
- **Idle/BUSY:** drive `htrans_in`=BUSY and IDLE → no state change, `data_hready_out`=1, `dmdata_out`=0.
